// File: rtl/inv_mix_columns_ctrl_pkg.sv
// Shared definitions for the InvMixColumns controller: FSM states, GF(2^8)
// coefficients, the AES reduction polynomial and state-byte index helpers.
// Byte k of a 128-bit AES state sits at bits [127-8k -: 8]; row = k%4, col = k/4.
package inv_mix_columns_ctrl_pkg;

    localparam int unsigned STATE_W   = 128;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_COEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Product index d = (r - r') mod 4 selects the coefficient in this order
    localparam logic [BYTE_W-1:0] COEF_0E  = 8'h0E;
    localparam logic [BYTE_W-1:0] COEF_0B  = 8'h0B;
    localparam logic [BYTE_W-1:0] COEF_0D  = 8'h0D;
    localparam logic [BYTE_W-1:0] COEF_09  = 8'h09;
    localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by a constant coefficient; folds to an XOR network
    function automatic logic [BYTE_W-1:0] gf_mul_const(input logic [BYTE_W-1:0] x,
                                                       input logic [BYTE_W-1:0] c);
        logic [BYTE_W-1:0] acc;
        logic [BYTE_W-1:0] pw;
        acc = '0;
        pw  = x;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ pw;
            pw = xtime(pw);
        end
        return acc;
    endfunction

    // Linear byte index from (row, col)
    function automatic logic [3:0] byte_idx(input logic [1:0] row, input logic [1:0] col);
        return {col, row};
    endfunction

    // LSB position of byte k: 8*(15-k)
    function automatic logic [6:0] byte_lsb(input logic [3:0] k);
        return {~k, 3'b000};
    endfunction

    function automatic logic [BYTE_W-1:0] state_byte(input logic [STATE_W-1:0] s,
                                                     input logic [3:0] k);
        return s[byte_lsb(k) +: BYTE_W];
    endfunction

endpackage

// File: rtl/inv_mix_columns_ctrl_byte.sv
// inv_mix_byte: combinational GF(2^8) multiplier producing the four
// InvMixColumns products of one state byte. No state.
//   in_byte   - byte to multiply
//   mul_0e_c  - in_byte * 0x0E
//   mul_0b_c  - in_byte * 0x0B
//   mul_0d_c  - in_byte * 0x0D
//   mul_09_c  - in_byte * 0x09
module inv_mix_byte
    import inv_mix_columns_ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] in_byte,
    output logic [BYTE_W-1:0] mul_0e_c,
    output logic [BYTE_W-1:0] mul_0b_c,
    output logic [BYTE_W-1:0] mul_0d_c,
    output logic [BYTE_W-1:0] mul_09_c
);

    always_comb begin
        mul_0e_c = gf_mul_const(in_byte, COEF_0E);
        mul_0b_c = gf_mul_const(in_byte, COEF_0B);
        mul_0d_c = gf_mul_const(in_byte, COEF_0D);
        mul_09_c = gf_mul_const(in_byte, COEF_09);
    end

endmodule

// File: rtl/inv_mix_columns_ctrl.sv
// inv_mix_columns_ctrl: iterative AES InvMixColumns with valid/ready handshakes.
// IDLE accepts a state, RUN accumulates byte products into a 128-bit
// accumulator, DONE presents the result until out_ready.
// Build option: INV_MIX_COL_PAR_EN - four multipliers, one column per cycle
// (4-cycle RUN); undefined - one multiplier, one byte per cycle (16-cycle RUN).
//   clk, rst   - clock, asynchronous active-high reset
//   in_valid   - input state offered;  in_ready - block can accept (IDLE)
//   in_state   - AES state, byte 0 at [127:120], column-major
//   out_valid  - result available;     out_ready - consumer accepts
//   out_state  - InvMixColumns(in_state), same byte order
//   busy       - high whenever not IDLE
module inv_mix_columns_ctrl
    import inv_mix_columns_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

`ifdef INV_MIX_COL_PAR_EN
    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 2;
`else
    localparam int unsigned LANES = 1;
    localparam int unsigned CNT_W = 4;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = '1;

    fsm_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] cap_q, cap_d;
    logic [STATE_W-1:0] acc_q, acc_d;
    logic [STATE_W-1:0] out_state_d;
    logic               in_ready_d, out_valid_d, busy_d;

    logic [LANES-1:0][BYTE_W-1:0]                mul_in_c;
    logic [LANES-1:0][NUM_COEF-1:0][BYTE_W-1:0]  mul_out_c;
    logic [STATE_W-1:0]                          acc_upd_c;

    // Byte multipliers; product slot d holds the coefficient for (r - r') mod 4
    for (genvar g = 0; g < LANES; g++) begin : g_mul
        inv_mix_byte u_mul (
            .in_byte  (mul_in_c[g]),
            .mul_0e_c (mul_out_c[g][0]),
            .mul_0b_c (mul_out_c[g][1]),
            .mul_0d_c (mul_out_c[g][2]),
            .mul_09_c (mul_out_c[g][3])
        );
    end

`ifdef INV_MIX_COL_PAR_EN
    // Whole column c = cnt_q per cycle: lane r carries row r
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            mul_in_c[r] = state_byte(cap_q, byte_idx(2'(r), cnt_q));
        end
        acc_upd_c = acc_q;
        for (int r = 0; r < 4; r++) begin
            for (int rp = 0; rp < 4; rp++) begin
                acc_upd_c[byte_lsb(byte_idx(2'(rp), cnt_q)) +: BYTE_W] ^=
                    mul_out_c[r][2'(2'(r) - 2'(rp))];
            end
        end
    end
`else
    // One byte per cycle: cnt_q is the linear byte index (row in [1:0], col in [3:2])
    always_comb begin
        mul_in_c[0] = state_byte(cap_q, cnt_q);
        acc_upd_c   = acc_q;
        for (int rp = 0; rp < 4; rp++) begin
            acc_upd_c[byte_lsb(byte_idx(2'(rp), cnt_q[3:2])) +: BYTE_W] ^=
                mul_out_c[0][2'(cnt_q[1:0] - 2'(rp))];
        end
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        acc_d       = acc_q;
        out_state_d = out_state;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    cap_d   = in_state;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_upd_c;
                if (cnt_q == LAST_CNT) begin
                    out_state_d = acc_upd_c;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cap_q     <= '0;
            acc_q     <= '0;
            out_state <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            acc_q     <= acc_d;
            out_state <= out_state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_ctrl.sv
// Self-checking bench for inv_mix_columns_ctrl: a matrix-form InvMixColumns
// model plus a handshake/latency model checked every cycle, and directed
// literal vectors. Honours INV_MIX_COL_PAR_EN for the expected latency.
module tb_inv_mix_columns_ctrl;

`ifdef INV_MIX_COL_PAR_EN
    localparam int LAT        = 5;
    localparam int ABORT_WAIT = 2;
`else
    localparam int LAT        = 17;
    localparam int ABORT_WAIT = 7;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    logic [127:0] exp_q[$];
    int acc_log[$];
    int hs_log[$];

    inv_mix_columns_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Apply a circulant column matrix with first row m0..m3
    function automatic logic [127:0] col_mix(input logic [127:0] s, input logic [7:0] m0,
                                             input logic [7:0] m1, input logic [7:0] m2,
                                             input logic [7:0] m3);
        logic [7:0] b[16];
        logic [7:0] m[4];
        logic [7:0] o;
        logic [127:0] res;
        m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
        for (int k = 0; k < 16; k++) b[k] = s[127 - 8*k -: 8];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o = 8'h00;
                for (int j = 0; j < 4; j++) o = o ^ gmul(m[j], b[4*c + ((r + j) % 4)]);
                res[127 - 8*(4*c + r) -: 8] = o;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        return col_mix(s, 8'h0E, 8'h0B, 8'h0D, 8'h09);
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        return col_mix(s, 8'h02, 8'h03, 8'h01, 8'h01);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        bit pending, exp_valid;
        if (rst) begin
            exp_q.delete();
            chk("rst_in_ready",  128'(in_ready),  128'(1'b1));
            chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
            chk("rst_busy",      128'(busy),      128'(1'b0));
            chk("rst_out_state", out_state,       '0);
        end else begin
            pending   = (exp_q.size() > 0);
            exp_valid = pending && ((cyc - last_acc) >= LAT);
            chk("busy",      128'(busy),      128'(pending));
            chk("in_ready",  128'(in_ready),  128'(!pending));
            chk("out_valid", 128'(out_valid), 128'(exp_valid));
            if (exp_valid && out_valid) chk("out_state", out_state, exp_q[0]);
            if (in_valid && !pending) begin
                exp_q.push_back(inv_mix(in_state));
                last_acc = cyc;
                acc_log.push_back(cyc);
            end
            if (exp_valid && out_ready) begin
                void'(exp_q.pop_front());
                hs_log.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic offer(input logic [127:0] s);
        int n = 0;
        in_state = s;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("offer_timeout", 128'(in_ready), 128'(1'b1));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic receive(output logic [127:0] res);
        int n = 0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 200) begin
                chk("receive_timeout", 128'(out_valid), 128'(1'b1));
                break;
            end
        end
        res = out_state;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    localparam logic [127:0] V0   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] E0   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] ONES = {16{8'h01}};

    initial begin
        logic [127:0] r1, r2, x;
        int base;

        // Model pins from hand-known vectors
        chk("model_e0",   inv_mix(V0), E0);
        chk("model_mix",  mix(E0), V0);
        chk("model_ones", inv_mix(ONES), ONES);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Known vector, zero vector, all-ones vector
        offer(V0);  receive(r1); settle(); out_ready = 1'b0; chk("vec_e0", r1, E0);
        offer('0);  receive(r1); settle(); out_ready = 1'b0; chk("vec_zero", r1, '0);
        offer(ONES); receive(r1); settle(); out_ready = 1'b0; chk("vec_ones", r1, ONES);

        // Stall for 20 cycles with in_valid/in_state churning
        offer(V0);
        while (!out_valid) settle();
        for (int i = 0; i < 20; i++) begin
            settle();
            in_valid = 1'($urandom_range(0, 1));
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("stall_in_ready",  128'(in_ready), 128'(1'b0));
            chk("stall_out_state", out_state, E0);
        end
        settle();
        in_valid = 1'b0;
        receive(r1); settle(); out_ready = 1'b0;
        chk("stall_result", r1, E0);

        // Back-to-back with out_ready held high
        base = acc_log.size();
        out_ready = 1'b1;
        fork
            begin offer(V0); offer(ONES); end
            begin receive(r1); receive(r2); end
        join
        settle();
        chk("b2b_first",  r1, E0);
        chk("b2b_second", r2, ONES);
        chk("b2b_gap", 128'(acc_log[base + 1] - hs_log[hs_log.size() - 2]), 128'(1));
        out_ready = 1'b0;

        // Abort mid-RUN, then a clean operation
        offer(32'hdeadbeef * 128'h1 + 128'h0123456789abcdef_0011223344556677);
        repeat (ABORT_WAIT) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_in_ready",  128'(in_ready),  128'(1'b1));
        chk("abort_out_valid", 128'(out_valid), 128'(1'b0));
        chk("abort_busy",      128'(busy),      128'(1'b0));
        chk("abort_out_state", out_state,       '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        offer(V0); receive(r1); settle(); out_ready = 1'b0;
        chk("post_abort", r1, E0);

        // Random round trips: MixColumns then the DUT restores the original
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            offer(mix(x));
            receive(r1);
            chk("roundtrip", r1, x);
        end
        settle();
        out_ready = 1'b0;
        repeat (3) settle();
        chk("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
